// File: rtl/vga_ddr_prefetch_ctrl.sv
// Prefetches a frame buffer from DDR in fixed-size bursts into a FWFT FIFO for VGA scan-out.
// Optional UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module vga_ddr_prefetch_ctrl #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          FRAME_WORDS = 153600,
    parameter int          BURST_LEN   = 16,
    parameter int          FIFO_DEPTH  = 64
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        ddr_init_done,
    input  logic        vga_frame_sync,
    input  logic        pix_rden,
    output logic [31:0] pix_data,
    output logic        pix_empty,
    output logic        ddr_rd_req,
    output logic [23:0] ddr_rd_addr,
    input  logic        ddr_rd_ack,
    input  logic        ddr_rd_valid,
    input  logic [31:0] ddr_rd_data,
    output logic        underflow
`ifdef UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam int BCW = $clog2(BURST_LEN) + 1;
    localparam int DW  = $clog2(BURST_LEN) + 2;

    typedef enum logic [2:0] {WAIT_INIT, IDLE, REQ, XFER, DONE} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [23:0]    addr_q, addr_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic [DW-1:0]  drop_q, drop_d, drop_abort, pending;
    logic           sync_q, underflow_q, underflow_d;
    logic [31:0]    fifo_mem [FIFO_DEPTH];

    logic           restart, dropping, xfer_beat, wr_en, rd_en, last_beat;
    logic [31:0]    frame_rem;
    logic [BCW-1:0] blen;

    // The first WAIT_INIT exit is itself a restart, so a frame always starts from a clean slate.
    assign restart   = (state_q == WAIT_INIT) ? ddr_init_done : (sync_q && !vga_frame_sync);
    // Beats still owed by an abandoned or shortened burst arrive first and are swallowed here.
    assign dropping  = ddr_rd_valid && (drop_q != '0);
    assign xfer_beat = ddr_rd_valid && (drop_q == '0) && (state_q == XFER);
    assign frame_rem = 32'(FRAME_WORDS) - 32'(word_cnt_q);
    assign blen      = (frame_rem >= 32'(BURST_LEN)) ? BCW'(BURST_LEN) : BCW'(frame_rem);
    assign last_beat = xfer_beat && (beat_q == blen - BCW'(1));
    assign wr_en     = xfer_beat && !restart && (beat_q < blen);
    assign rd_en     = pix_rden && (count_q != '0) && !restart;

    always_comb begin
        pending = '0;
        if (state_q == XFER)
            pending = DW'(BURST_LEN) - DW'(beat_q) - DW'(xfer_beat);
        else if (state_q == REQ && ddr_rd_ack)
            pending = DW'(BURST_LEN);
    end
    assign drop_abort = drop_q - DW'(dropping) + pending;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_cnt_d  = word_cnt_q;
        beat_d      = beat_q;
        drop_d      = drop_q - DW'(dropping);
        wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(wr_en) - CW'(rd_en);
        underflow_d = underflow_q || (pix_rden && pix_empty);
        case (state_q)
            WAIT_INIT: ;
            IDLE: begin
                // Outstanding beats are always zero here, so free space is just depth minus count.
                if ((32'(FIFO_DEPTH) - 32'(count_q)) >= 32'(BURST_LEN) &&
                    32'(word_cnt_q) < 32'(FRAME_WORDS))
                    state_d = REQ;
            end
            REQ: begin
                if (ddr_rd_ack) begin
                    state_d = XFER;
                    beat_d  = '0;
                end
            end
            XFER: begin
                if (xfer_beat) begin
                    beat_d = beat_q + BCW'(1);
                    if (last_beat) begin
                        addr_d     = addr_q + 24'(BURST_LEN);
                        word_cnt_d = word_cnt_q + WCW'(blen);
                        drop_d     = drop_abort;
                        state_d    = ((32'(word_cnt_q) + 32'(blen)) == 32'(FRAME_WORDS)) ? DONE : IDLE;
                    end
                end
            end
            DONE: ;
            default: state_d = WAIT_INIT;
        endcase
        if (restart) begin
            state_d     = IDLE;
            addr_d      = BASE_ADDR;
            word_cnt_d  = '0;
            beat_d      = '0;
            drop_d      = drop_abort;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q     <= WAIT_INIT;
            addr_q      <= BASE_ADDR;
            word_cnt_q  <= '0;
            beat_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sync_q      <= 1'b0;
            underflow_q <= 1'b0;
            // The DDR still returns beats of a burst accepted before reset; keep owing them.
            case (state_q)
                REQ, XFER:             drop_q <= drop_abort;
                WAIT_INIT, IDLE, DONE: drop_q <= drop_q - DW'(dropping);
                default:               drop_q <= '0;
            endcase
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_cnt_q  <= word_cnt_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sync_q      <= vga_frame_sync;
            underflow_q <= underflow_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (wr_en)
            fifo_mem[wr_ptr_q] <= ddr_rd_data;
    end

    assign ddr_rd_req  = (state_q == REQ);
    assign ddr_rd_addr = addr_q;
    assign pix_empty   = (count_q == '0);
    assign pix_data    = pix_empty ? 32'd0 : fifo_mem[rd_ptr_q];
    assign underflow   = underflow_q;

`ifdef UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (pix_rden && pix_empty && ucnt_q != 16'hFFFF)
            ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge vga_clk) begin
        if (rst)
            ucnt_q <= '0;
        else
            ucnt_q <= ucnt_d;
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: doc/vga_ddr_prefetch_ctrl.md
VGA_DDR_PREFETCH_CTRL -- requirements
Module: vga_ddr_prefetch_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000, meaning DDR word address of pixel (0,0).
REQ-002 SHALL have parameter FRAME_WORDS, default 153600, meaning 32-bit words per frame (640x480 RGB565, 2 px/word).
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning words per DDR read request (power of 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, meaning prefetch FIFO words (power of 2, >= 2*BURST_LEN).
REQ-005 SHALL have port vga_clk, input, 1, meaning sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-007 SHALL have port ddr_init_done, input, 1, meaning DDR calibration complete.
REQ-008 SHALL have port vga_frame_sync, input, 1, meaning vertical active window, high during active lines.
REQ-009 SHALL have port pix_rden, input, 1, meaning display pops one word this cycle.
REQ-010 SHALL have port pix_data, output, 32, meaning FIFO head word, [31:16] first pixel, [15:0] second.
REQ-011 SHALL have port pix_empty, output, 1, meaning FIFO holds no word.
REQ-012 SHALL have port ddr_rd_req, output, 1, meaning burst read request, held until accepted.
REQ-013 SHALL have port ddr_rd_addr, output, 24, meaning burst start word address.
REQ-014 SHALL have port ddr_rd_ack, input, 1, meaning DDR accepts request this cycle.
REQ-015 SHALL have port ddr_rd_valid, input, 1, meaning one returned word on ddr_rd_data.
REQ-016 SHALL have port ddr_rd_data, input, 32, meaning returned read word.
REQ-017 SHALL have port underflow, output, 1, meaning sticky: pop seen while empty this frame.

Function
REQ-018 FSM states SHALL be WAIT_INIT, IDLE, REQ, XFER, DONE.
REQ-019 WAIT_INIT SHALL go to IDLE when ddr_init_done=1; no request issued before.
REQ-020 A frame restart SHALL occur on falling edge of vga_frame_sync (registered, 1-cycle detect) and on first IDLE entry.
REQ-021 On restart: FIFO flushed, word counter=0, next address=BASE_ADDR, underflow cleared, FSM to IDLE, any XFER in flight finished by discarding its remaining beats.
REQ-022 IDLE SHALL go to REQ when free space (FIFO_DEPTH minus count minus outstanding beats) >= BURST_LEN and word counter < FRAME_WORDS.
REQ-023 REQ SHALL assert ddr_rd_req with stable ddr_rd_addr until ddr_rd_ack, then go to XFER; req/addr SHALL not change while req high.
REQ-024 XFER SHALL write each ddr_rd_valid beat into FIFO; after BURST_LEN beats, address += BURST_LEN, counter += BURST_LEN, go to DONE if counter = FRAME_WORDS else IDLE.
REQ-025 Final burst SHALL be shortened to not exceed FRAME_WORDS; extra beats never written.
REQ-026 DONE SHALL hold until restart; no requests issued.
REQ-027 pix_data SHALL be first-word-fall-through; valid same cycle pix_empty=0; pop takes effect next edge.
REQ-028 Simultaneous write and pop SHALL leave count unchanged; pop when empty SHALL not change count and SHALL set underflow.
REQ-029 FIFO SHALL never overflow; pointers wrap modulo FIFO_DEPTH.
REQ-030 ddr_rd_valid outside XFER SHALL be ignored.

Reset
REQ-031 rst=1 at a rising edge SHALL set FSM=WAIT_INIT, FIFO empty, ddr_rd_req=0, ddr_rd_addr=BASE_ADDR, pix_empty=1, pix_data=0, underflow=0.
REQ-032 Reset mid-burst SHALL drop ddr_rd_req next cycle and discard all later beats until restart.

Configuration
REQ-033 With UNDERFLOW_CNT_EN defined: extra output underflow_cnt [15:0] SHALL count underflowing pops, saturating at 16'hFFFF, cleared only by rst.
REQ-034 Without UNDERFLOW_CNT_EN: port underflow_cnt and its logic SHALL be absent; all else identical.

Verification
REQ-035 ddr_init_done=0 for 100 cycles -> ddr_rd_req stays 0; after 1 -> first req with addr=BASE_ADDR.
REQ-036 ack immediately, 16 beats, no pops -> requests at addr 0,16,32,48, then stall with FIFO count=64.
REQ-037 FRAME_WORDS=40, BURST_LEN=16 -> bursts of 16,16,8 at addr 0,16,32; DONE; no 4th request.
REQ-038 Pop on empty FIFO -> underflow=1, count unchanged; with UNDERFLOW_CNT_EN, 3 such pops -> underflow_cnt=3.
REQ-039 vga_frame_sync falls during burst beat 5 -> remaining beats discarded, FIFO empty, next req addr=BASE_ADDR.
REQ-040 rst pulsed while ddr_rd_req=1 -> req=0 next cycle, state WAIT_INIT, pix_empty=1.
